booth_mult_arbiter: RTL and testbench
=====================================

Name: booth_mult_arbiter

Overview:
Round-robin scheduler that shares one sequential Booth multiplier (operand datapath plus its control unit) between N_REQ requesters. It accepts a valid/ready operand request, latches the operands, pulses the multiplier start, and waits for done under a watchdog. It then returns the signed product with the requester ID over a valid/ready response channel. It sits between the client blocks and the multiplier core, and is the only driver of the multiplier's start and operand inputs.

Parameters:
N_REQ, 4, number of requesters (2..8); ID_W = clog2(N_REQ) is a derived localparam.
WIDTH, 8, operand width in bits, two's complement; product is 2*WIDTH bits.
TIMEOUT, 64, maximum cycles in WAIT before the transaction is aborted; counter width is clog2(TIMEOUT+1).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  N_REQ  per-requester request valid.
req_ready  out  N_REQ  per-requester accept; one-hot or zero.
req_a  in  N_REQ*WIDTH  multiplicands, requester i at bits [i*WIDTH +: WIDTH].
req_b  in  N_REQ*WIDTH  multipliers, same packing.
mul_start  out  1  one-cycle start pulse to the multiplier.
mul_a  out  WIDTH  latched multiplicand.
mul_b  out  WIDTH  latched multiplier.
mul_done  in  1  multiplier completion; sampled only in WAIT.
mul_product  in  2*WIDTH  multiplier result; valid with mul_done.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response accept.
rsp_id  out  ID_W  index of the granted requester.
rsp_product  out  2*WIDTH  signed product; 0 on error.
rsp_err  out  1  watchdog abort flag, qualified by rsp_valid.
busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, mul_a=mul_b=0, rsp_product=0, rsp_err=0, wd_cnt=0. All outputs 0.
- Reset mid-operation: immediate return to IDLE. Any in-flight transaction is dropped with no response. The multiplier core shares rst.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant = first i with req_valid[i], searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1 .. N_REQ-1, 0 .. rr_ptr-1).
  - req_ready[grant] is asserted combinationally in the same cycle. The handshake completes at that edge: latch req_a/req_b slices into mul_a/mul_b, grant into grant_id, then go to ISSUE.
  - If no req_valid is set, stay in IDLE with req_ready=0.
- ISSUE: mul_start=1 for exactly this cycle. Clear wd_cnt. Go to WAIT. mul_done is ignored here.
- WAIT:
  - mul_done=1: capture mul_product into rsp_product, set rsp_err=0, go to RESP.
  - Otherwise wd_cnt increments. When wd_cnt reaches TIMEOUT-1 without done: rsp_product=0, rsp_err=1, go to RESP.
  - mul_done and the watchdog expiring in the same cycle: done wins, rsp_err=0.
- RESP:
  - rsp_valid=1. rsp_id, rsp_product and rsp_err stay stable until rsp_ready.
  - On rsp_valid and rsp_ready: rr_ptr = (grant_id+1) mod N_REQ (wraps at N_REQ-1), then go to IDLE.
  - Requests arriving meanwhile wait; req_ready stays 0 outside IDLE.
- Latency: grant-to-start is 1 cycle. Done-to-rsp_valid is 1 cycle. Minimum spacing between grants is 3 + multiplier latency + response stall cycles.
- Fairness: a requester holding req_valid high is granted within N_REQ transactions.
- Requester rule: req_a/req_b must be stable while req_valid=1 and req_ready=0. Dropping req_valid before grant is legal.
- mul_a/mul_b hold their value from grant until the next grant.

Decomposition:
- Package booth_pkg: state enum typedef (IDLE, ISSUE, WAIT, RESP), default WIDTH, TIMEOUT and N_REQ constants, clog2-derived width helpers.
- Sub-module rr_arbiter (combinational): inputs req vector and rr_ptr; outputs grant_valid and grant_id. It is instantiated once. FSM, latches and watchdog stay in booth_mult_arbiter.

Test Plan:
- Single request, WIDTH=8, mock multiplier with done 4 cycles after start: req0 a=0xFD (-3), b=0x05 -> req_ready[0] same cycle, mul_start next cycle, rsp_valid with rsp_id=0, rsp_product=0xFFF1 (-15), rsp_err=0.
- All four req_valid held high continuously -> grant order 0,1,2,3,0. Products 2*3=0x0006, 0x7F*0x7F=0x3F01, 0x80*0x80=0x4000, 0x80*0x7F=0xC080 on ids 1..3.
- Watchdog: mock never asserts done, TIMEOUT=64 -> rsp_valid TIMEOUT cycles after mul_start with rsp_err=1 and rsp_product=0; next grant goes to the following requester.
- Back-pressure: rsp_ready held 0 for 10 cycles -> rsp_* stable throughout, no req_ready, busy=1; rsp_ready=1 -> IDLE next cycle.
- Reset in WAIT: rst asserted asynchronously mid-cycle -> all outputs 0 immediately, no response; after release, req2 is granted first with rr_ptr=0.
- Done and watchdog coincide (done asserted on wd_cnt=TIMEOUT-1) -> rsp_err=0, rsp_product = mock product.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier request scheduler.
package booth_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic             o_grant_valid,
  output logic [ID_W-1:0]  o_grant_id
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [ID_W-1:0]    w_off;
  logic [ID_W:0]      w_sum;

  // Rotating a doubled copy puts requester (ptr+k) mod N_REQ at bit k.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N_REQ-1:0];

  always_comb begin
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = ID_W'(k);
    end
  end

  assign w_sum         = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_grant_id    = (w_sum >= (ID_W+1)'(N_REQ)) ? ID_W'(w_sum - (ID_W+1)'(N_REQ))
                                                     : w_sum[ID_W-1:0];
  assign o_grant_valid = |i_req;

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end sharing one sequential Booth multiplier among N_REQ clients.
// Latches operands at grant, runs the core under a watchdog, returns product and id.
module booth_mult_arbiter
  import booth_pkg::*;
#(
  parameter int  N_REQ   = DEF_N_REQ,
  parameter int  WIDTH   = DEF_WIDTH,
  parameter int  TIMEOUT = DEF_TIMEOUT,
  localparam int ID_W    = id_width(N_REQ),
  localparam int CNT_W   = cnt_width(TIMEOUT)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req_valid,
  output logic [N_REQ-1:0]       o_req_ready,
  input  logic [N_REQ*WIDTH-1:0] i_req_a,
  input  logic [N_REQ*WIDTH-1:0] i_req_b,
  output logic                   o_mul_start,
  output logic [WIDTH-1:0]       o_mul_a,
  output logic [WIDTH-1:0]       o_mul_b,
  input  logic                   i_mul_done,
  input  logic [2*WIDTH-1:0]     i_mul_product,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [ID_W-1:0]        o_rsp_id,
  output logic [2*WIDTH-1:0]     o_rsp_product,
  output logic                   o_rsp_err,
  output logic                   o_busy
);

  state_t             r_state;
  state_t             w_state_next;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_grant_id;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic [2*WIDTH-1:0] r_rsp_product;
  logic               r_rsp_err;
  logic [CNT_W-1:0]   r_wd_cnt;

  logic               w_grant_valid;
  logic [ID_W-1:0]    w_grant_id;
  logic [N_REQ-1:0]   w_grant_onehot;
  logic               w_wd_expire;
  logic [WIDTH-1:0]   w_req_a [N_REQ];
  logic [WIDTH-1:0]   w_req_b [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_req_a[gi] = i_req_a[gi*WIDTH +: WIDTH];
      assign w_req_b[gi] = i_req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .i_req         (i_req_valid),
    .i_ptr         (r_rr_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  assign w_grant_onehot = N_REQ'(1) << w_grant_id;
  // Expiry fires on the last WAIT cycle, so the count lands on TIMEOUT-1 (needs TIMEOUT >= 2).
  assign w_wd_expire    = (r_wd_cnt == CNT_W'(TIMEOUT - 2));

  always_comb begin
    w_state_next = r_state;
    o_req_ready  = '0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_state_next = ISSUE;
          if (!i_rst) o_req_ready = w_grant_onehot;
        end
      end
      ISSUE: w_state_next = WAIT;
      WAIT:  if (i_mul_done || w_wd_expire) w_state_next = RESP;
      RESP:  if (i_rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_rsp_product <= '0;
      r_rsp_err     <= 1'b0;
      r_wd_cnt      <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_mul_a    <= w_req_a[w_grant_id];
            r_mul_b    <= w_req_b[w_grant_id];
            r_grant_id <= w_grant_id;
          end
        end
        ISSUE: r_wd_cnt <= '0;
        WAIT: begin
          // A done arriving with the watchdog expiry still counts as success.
          if (i_mul_done) begin
            r_rsp_product <= i_mul_product;
            r_rsp_err     <= 1'b0;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
            if (w_wd_expire) begin
              r_rsp_product <= '0;
              r_rsp_err     <= 1'b1;
            end
          end
        end
        RESP: begin
          if (i_rsp_ready)
            r_rr_ptr <= (r_grant_id == ID_W'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_mul_start   = (r_state == ISSUE);
  assign o_mul_a       = r_mul_a;
  assign o_mul_b       = r_mul_b;
  assign o_rsp_valid   = (r_state == RESP);
  assign o_rsp_id      = r_grant_id;
  assign o_rsp_product = r_rsp_product;
  assign o_rsp_err     = r_rsp_err;
  assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Self-checking bench: directed table, reset-in-WAIT sequence, randomized traffic vs. a model.
module tb_booth_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     pend;
  logic [W-1:0]     op_a [N];
  logic [W-1:0]     op_b [N];
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic             rsp_ready;
  logic [N-1:0]     req_ready;
  logic             mul_start;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic             mul_done;
  logic [2*W-1:0]   m_prod;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [2*W-1:0]   rsp_product;
  logic             rsp_err;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt;
  int mock_lat = 0;
  int ptr_m;

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
  end

  booth_mult_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (pend),
    .o_req_ready   (req_ready),
    .i_req_a       (req_a),
    .i_req_b       (req_b),
    .o_mul_start   (mul_start),
    .o_mul_a       (mul_a),
    .o_mul_b       (mul_b),
    .i_mul_done    (mul_done),
    .i_mul_product (m_prod),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_id      (rsp_id),
    .o_rsp_product (rsp_product),
    .o_rsp_err     (rsp_err),
    .o_busy        (busy)
  );

  // Mock multiplier: done pulses mock_lat cycles after start (never when mock_lat is 0).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_prod <= '0;
    end else if (mul_start) begin
      m_cnt  <= 1;
      m_prod <= $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b});
    end else if (m_cnt != 0 && m_cnt < 1000) begin
      m_cnt <= m_cnt + 1;
    end
  end
  assign mul_done = (mock_lat != 0) && (m_cnt == mock_lat);

  typedef struct {
    int         rq;
    logic [7:0] a;
    logic [7:0] b;
    bit         run;
    int         lat;
    int         stall;
    int         exp_id;
    logic [15:0] exp_prod;
    bit         exp_err;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] p, input int ptr);
    for (int k = 0; k < N; k++)
      if (p[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  function automatic logic [15:0] model_prod(input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    int r;
    sa = $signed(a);
    sb = $signed(b);
    r  = sa * sb;
    return r[15:0];
  endfunction

  // Called at a negedge with requests set; returns at a negedge after the response is taken.
  task automatic step_txn(input int exp_id, input logic [15:0] exp_prod, input bit exp_err,
                          input int lat, input int stall);
    int         n;
    int         cyc;
    int         exp_cyc;
    bit         extra;
    logic [1:0] eid;
    eid      = exp_id[1:0];
    mock_lat = lat;
    n        = 0;
    #1;
    while (req_ready == '0 && n < 8) begin
      @(negedge clk); #1;
      n++;
    end
    chk("req_ready_onehot", 32'(req_ready), 32'(1) << exp_id);
    if (req_ready == '0) return;
    @(posedge clk); #1;
    pend[exp_id] = 1'b0;
    @(negedge clk);
    chk("mul_start", 32'(mul_start), 1);
    chk("mul_a", 32'(mul_a), 32'(op_a[exp_id]));
    chk("mul_b", 32'(mul_b), 32'(op_b[exp_id]));
    cyc   = 0;
    extra = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (mul_start || req_ready != '0) extra = 1'b1;
    end while (!rsp_valid && cyc < TO + 8);
    exp_cyc = (lat >= 1 && lat <= TO - 1) ? lat + 1 : TO;
    chk("start_to_rsp_cycles", 32'(cyc), 32'(exp_cyc));
    chk("quiet_while_busy", 32'(extra), 0);
    chk("rsp_id", 32'(rsp_id), 32'(exp_id));
    chk("rsp_product", 32'(rsp_product), 32'(exp_prod));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("rsp_hold_stable",
          32'({rsp_valid, busy, (req_ready == '0), rsp_err, rsp_id, rsp_product}),
          32'({1'b1, 1'b1, 1'b1, exp_err, eid, exp_prod}));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_rsp", 32'({rsp_valid, busy}), 0);
    ptr_m = (exp_id + 1) % N;
    $display("[TB] txn id=%0d prod=%h err=%0d lat=%0d stall=%0d", exp_id, rsp_product,
             rsp_err, lat, stall);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{0, 8'hFD, 8'h05, 1'b1, 4,  0,  0, 16'hFFF1, 1'b0};
    tbl[1]  = '{1, 8'h02, 8'h03, 1'b0, 0,  0,  0, 16'h0000, 1'b0};
    tbl[2]  = '{2, 8'h7F, 8'h7F, 1'b0, 0,  0,  0, 16'h0000, 1'b0};
    tbl[3]  = '{3, 8'h80, 8'h80, 1'b0, 0,  0,  0, 16'h0000, 1'b0};
    tbl[4]  = '{0, 8'h80, 8'h7F, 1'b1, 4,  0,  1, 16'h0006, 1'b0};
    tbl[5]  = '{1, 8'h01, 8'h01, 1'b1, 3,  0,  2, 16'h3F01, 1'b0};
    tbl[6]  = '{2, 8'hFF, 8'hFF, 1'b1, 5,  0,  3, 16'h4000, 1'b0};
    tbl[7]  = '{3, 8'h05, 8'hFA, 1'b1, 2,  10, 0, 16'hC080, 1'b0};
    tbl[8]  = '{0, 8'h11, 8'hF0, 1'b1, 0,  0,  1, 16'h0000, 1'b1};
    tbl[9]  = '{1, 8'h03, 8'h03, 1'b1, TO - 1, 0, 2, 16'h0001, 1'b0};
    tbl[10] = '{2, 8'h7F, 8'h80, 1'b1, TO, 0,  3, 16'h0000, 1'b1};
    tbl[11] = '{3, 8'h80, 8'h01, 1'b1, 1,  0,  0, 16'hFEF0, 1'b0};

    rst       = 1'b1;
    pend      = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    ptr_m = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        32'({req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, rsp_err, busy}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_request", 32'({req_ready, busy}), 0);

    for (int e = 0; e < 12; e++) begin
      op_a[tbl[e].rq] = tbl[e].a;
      op_b[tbl[e].rq] = tbl[e].b;
      pend[tbl[e].rq] = 1'b1;
      if (tbl[e].run)
        step_txn(tbl[e].exp_id, tbl[e].exp_prod, tbl[e].exp_err, tbl[e].lat, tbl[e].stall);
    end

    // Requester 1 withdraws; requester 2 is served so the pointer moves to 3.
    pend[1] = 1'b0;
    step_txn(2, 16'hC080, 1'b0, 5, 0);

    // Reset while requester 3 sits in WAIT with a multiplier that never finishes.
    mock_lat = 0;
    #1;
    chk("grant_before_reset", 32'(req_ready), 32'h8);
    @(posedge clk); #1;
    pend[3] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("in_wait_before_reset", 32'({busy, mul_start, rsp_valid}), 32'h4);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs",
        32'({req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, rsp_err, busy}), 0);
    op_a[2] = 8'h9C;
    op_b[2] = 8'h07;
    pend[2] = 1'b1;
    pend[3] = 1'b1;
    #1;
    chk("ready_blocked_in_reset", 32'(req_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    ptr_m = 0;
    step_txn(2, 16'hFD44, 1'b0, 4, 0);

    for (int t = 0; t < 40; t++) begin
      int r;
      int lat;
      int stall;
      int eid;
      bit err;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          op_a[i] = 8'($urandom);
          op_b[i] = 8'($urandom);
          pend[i] = 1'b1;
        end
      end
      if (pend == '0) begin
        r       = $urandom_range(N - 1, 0);
        op_a[r] = 8'($urandom);
        op_b[r] = 8'($urandom);
        pend[r] = 1'b1;
      end
      r     = $urandom_range(19, 0);
      lat   = (r == 0) ? 0 : (r == 1) ? TO - 1 : (r == 2) ? TO : $urandom_range(8, 1);
      stall = $urandom_range(3, 0);
      err   = (lat == 0) || (lat >= TO);
      eid   = model_grant(pend, ptr_m);
      step_txn(eid, err ? 16'h0000 : model_prod(op_a[eid], op_b[eid]), err, lat, stall);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
